// File: rtl/abc_seq_driver.sv
// abc_seq_driver
//   Issues bursts of a -> b -> c stimulus pulses. Each sequence drives a, b
//   and c high for one cycle each, in consecutive cycles. An optional idle
//   gap separates consecutive sequences. A burst is requested with start
//   and runs for the number of sequences given by rpt. err_mode can
//   suppress either b or c to inject faults.
//
// Ports
//   clk       : clock, all state updates on its rising edge
//   rst_n     : asynchronous active-low reset
//   start     : burst request, accepted only while idle (and abort low)
//   rpt       : number of a/b/c sequences, sampled on accepted start
//   gap       : idle cycles between sequences, sampled on accepted start
//   err_mode  : 00/11 normal, 01 suppress b, 10 suppress c
//   abort     : terminates the burst immediately (no done pulse)
//   a, b, c   : stimulus outputs, decoded from the state register
//   busy      : high whenever the block is not idle
//   done      : one-cycle pulse when a burst completes normally
//   seq_cnt   : number of sequences completed in the current/last burst
module abc_seq_driver #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rpt,
  input  logic [GAP_W-1:0] gap,
  input  logic [1:0]       err_mode,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seq_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    GAP  = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] rpt_reg, rpt_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             sup_b_reg, sup_b_next;
  logic             sup_c_reg, sup_c_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] seq_cnt_reg, seq_cnt_next;
  logic [CNT_W-1:0] seq_cnt_inc;

  // PH_C is only ever entered with seq_cnt < rpt (rpt >= 1), so this
  // increment can never wrap past the all-ones count.
  assign seq_cnt_inc = seq_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rpt_reg     <= '0;
      gap_reg     <= '0;
      sup_b_reg   <= 1'b0;
      sup_c_reg   <= 1'b0;
      gap_cnt_reg <= '0;
      seq_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rpt_reg     <= rpt_next;
      gap_reg     <= gap_next;
      sup_b_reg   <= sup_b_next;
      sup_c_reg   <= sup_c_next;
      gap_cnt_reg <= gap_cnt_next;
      seq_cnt_reg <= seq_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rpt_next     = rpt_reg;
    gap_next     = gap_reg;
    sup_b_next   = sup_b_reg;
    sup_c_next   = sup_c_reg;
    gap_cnt_next = gap_cnt_reg;
    seq_cnt_next = seq_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          rpt_next     = rpt;
          gap_next     = gap;
          // err_mode 11 decodes to neither suppression, i.e. normal.
          sup_b_next   = (err_mode == 2'b01);
          sup_c_next   = (err_mode == 2'b10);
          seq_cnt_next = '0;
          state_next   = (rpt != '0) ? PH_A : FIN;
        end
      end
      PH_A: state_next = PH_B;
      PH_B: state_next = PH_C;
      PH_C: begin
        seq_cnt_next = seq_cnt_inc;
        if (seq_cnt_inc == rpt_reg) begin
          state_next = FIN;
        end else if (gap_reg == '0) begin
          state_next = PH_A;
        end else begin
          // Count down remaining gap cycles; GAP exits when this hits zero.
          gap_cnt_next = gap_reg - GAP_W'(1);
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = PH_A;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort overrides everything in an active burst: the count is frozen
    // (a sequence aborted in PH_C does not count) and no done is produced.
    if (abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      seq_cnt_next = seq_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
    end
  end

  assign a       = (state_reg == PH_A);
  assign b       = (state_reg == PH_B) && !sup_b_reg;
  assign c       = (state_reg == PH_C) && !sup_c_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == FIN);
  assign seq_cnt = seq_cnt_reg;

endmodule
